sw_conditioner: RTL

Input conditioning stage between the DE0 slide switches and `cpu`. Synchronises the raw `SW[9:0]` bus into the CPU clock domain, debounces every bit, and turns the handshake switch (SW8) into clean one-cycle rise/fall strobes. On each handshake rise it latches the debounced data byte `SW[7:0]` for the CPU. It runs on the same slow `clk` as `cpu`, so there is no further clock crossing.

---
 rtl/sw_conditioner.sv | 91 +++++++++
 1 files changed

// File: rtl/sw_conditioner.sv
// Switch input conditioning: two-flop synchroniser, per-bit debounce,
// handshake edge strobes and a data byte latched on handshake rise.
module sw_conditioner #(
  parameter int WIDTH         = 10,
  parameter int DATA_W        = 8,
  parameter int HS_BIT        = 8,
  parameter int STABLE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  SW,
  output logic [WIDTH-1:0]  sw_db,
  output logic              hs_rise,
  output logic              hs_fall,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0]         s1_q, s1_d;
  logic [WIDTH-1:0]         s2_q, s2_d;
  logic [WIDTH-1:0]         db_q, db_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic                     hs_rise_q, hs_rise_d;
  logic                     hs_fall_q, hs_fall_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic                     valid_q, valid_d;

  always_comb begin
    s1_d  = SW;
    s2_d  = s1_q;
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CMAX) begin
        db_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Strobes and latch look at the post-update debounced value so that
  // data bits settling on the handshake edge are captured too.
  always_comb begin
    hs_rise_d = db_d[HS_BIT] & ~db_q[HS_BIT];
    hs_fall_d = ~db_d[HS_BIT] & db_q[HS_BIT];
    data_d    = data_q;
    valid_d   = valid_q;
    if (hs_rise_d) begin
      data_d  = db_d[DATA_W-1:0];
      valid_d = 1'b1;
    end else if (hs_fall_d) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      cnt_q     <= '0;
      hs_rise_q <= 1'b0;
      hs_fall_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      hs_rise_q <= hs_rise_d;
      hs_fall_q <= hs_fall_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  assign sw_db      = db_q;
  assign hs_rise    = hs_rise_q;
  assign hs_fall    = hs_fall_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;

endmodule
